alu_result_log: RTL and testbench

ALU_RESULT_LOG -- requirements
Module: alu_result_log

---
 rtl/alu_result_log_pkg.sv | 13 +
 rtl/alu_result_log_edge_pulse.sv | 29 ++
 rtl/alu_result_log.sv | 170 +++++++++++++++++
 tb/tb_alu_result_log.sv | 135 +++++++++++++
 4 files changed

// File: rtl/alu_result_log_pkg.sv
// Shared types and default sizing for the ALU result log.
package alu_result_log_pkg;

    // View mode: LIVE follows the newest entry, BROWSE holds an age.
    typedef enum logic {
        LIVE   = 1'b0,
        BROWSE = 1'b1
    } state_e;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/alu_result_log_edge_pulse.sv
// Registered rising-edge detector used for key/switch style controls.
// Only compiled when ALU_RESULT_LOG_EDGE_DETECT_EN is defined; the pulse
// is registered, so each edge acts one clock after it is seen.
`ifdef ALU_RESULT_LOG_EDGE_DETECT_EN
module edge_pulse (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_r;
    logic pulse_r;

    // Remember the previous level and emit a one-cycle pulse on 0->1.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_r <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            level_r <= level;
            pulse_r <= level & ~level_r;
        end
    end

    assign pulse = pulse_r;

endmodule
`endif

// File: rtl/alu_result_log.sv
// Circular log of ALU results with a browsable view of older entries.
// Optional macro ALU_RESULT_LOG_EDGE_DETECT_EN: browse_prev, browse_next
// and clear become level inputs acting once per rising edge.
module alu_result_log
    import alu_result_log_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       browse_prev,
    input  logic                       browse_next,
    input  logic                       clear,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH)-1:0]   out_age,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       live
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic [AW-1:0]    age_r;
    state_e           state_r;
    logic [WIDTH-1:0] out_data_r;
    logic             full_r;

    logic [AW-1:0]    wr_ptr_s;
    logic [CW-1:0]    count_s;
    logic [AW-1:0]    age_s;
    state_e           state_s;
    logic             wr_en_s;
    logic [AW-1:0]    idx_s;
    logic [WIDTH-1:0] out_data_s;
    logic [AW+1:0]    age_sum_s;
    logic [AW+1:0]    age_cap_s;
    logic             prev_ev_s;
    logic             next_ev_s;
    logic             clear_ev_s;
    logic             step_prev_s;
    logic             step_next_s;

`ifdef ALU_RESULT_LOG_EDGE_DETECT_EN
    edge_pulse u_prev  (.clock(clock), .reset(reset), .level(browse_prev), .pulse(prev_ev_s));
    edge_pulse u_next  (.clock(clock), .reset(reset), .level(browse_next), .pulse(next_ev_s));
    edge_pulse u_clear (.clock(clock), .reset(reset), .level(clear),       .pulse(clear_ev_s));
`else
    assign prev_ev_s  = browse_prev;
    assign next_ev_s  = browse_next;
    assign clear_ev_s = clear;
`endif

    // Opposing browse requests in the same cycle cancel each other.
    assign step_prev_s = prev_ev_s & ~next_ev_s;
    assign step_next_s = next_ev_s & ~prev_ev_s;

    // Next-state logic: clear wins, then write bookkeeping, then view update.
    always_comb begin
        wr_ptr_s  = wr_ptr_r;
        count_s   = count_r;
        age_s     = age_r;
        state_s   = state_r;
        wr_en_s   = 1'b0;
        age_sum_s = {(AW+2){1'b0}};
        age_cap_s = {(AW+2){1'b0}};
        if (clear_ev_s) begin
            wr_ptr_s = {AW{1'b0}};
            count_s  = {CW{1'b0}};
            age_s    = {AW{1'b0}};
            state_s  = LIVE;
        end else begin
            if (in_valid) begin
                wr_en_s  = 1'b1;
                wr_ptr_s = wr_ptr_r + AW'(1'b1);
                if (count_r == CW'(DEPTH)) begin
                    count_s = count_r;
                end else begin
                    count_s = count_r + CW'(1'b1);
                end
            end else begin
                wr_en_s = 1'b0;
            end
            age_cap_s = (AW+2)'(count_s) - (AW+2)'(1'b1);
            case (state_r)
                LIVE: begin
                    if (step_prev_s && (count_s >= CW'(2'd2))) begin
                        state_s = BROWSE;
                        age_s   = AW'(1'b1);
                    end else begin
                        state_s = LIVE;
                        age_s   = {AW{1'b0}};
                    end
                end
                BROWSE: begin
                    // A write ages the viewed entry by one, keeping it in view.
                    age_sum_s = (AW+2)'(age_r) + (AW+2)'(in_valid)
                              + (AW+2)'(step_prev_s) - (AW+2)'(step_next_s);
                    if (age_sum_s > age_cap_s) begin
                        age_sum_s = age_cap_s;
                    end else begin
                        age_sum_s = age_sum_s;
                    end
                    if (age_sum_s == {(AW+2){1'b0}}) begin
                        state_s = LIVE;
                        age_s   = {AW{1'b0}};
                    end else begin
                        state_s = BROWSE;
                        age_s   = age_sum_s[AW-1:0];
                    end
                end
                default: begin
                    state_s = LIVE;
                    age_s   = {AW{1'b0}};
                end
            endcase
        end
    end

    // Viewed entry for the next cycle, forwarding the slot being written now.
    always_comb begin
        idx_s = wr_ptr_s - AW'(1'b1) - age_s;
        if (count_s == {CW{1'b0}}) begin
            out_data_s = {WIDTH{1'b0}};
        end else if (wr_en_s && (idx_s == wr_ptr_r)) begin
            out_data_s = in_data;
        end else begin
            out_data_s = mem_r[idx_s];
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (!reset && !clear_ev_s && wr_en_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            age_r      <= {AW{1'b0}};
            state_r    <= LIVE;
            out_data_r <= {WIDTH{1'b0}};
            full_r     <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_s;
            count_r    <= count_s;
            age_r      <= age_s;
            state_r    <= state_s;
            out_data_r <= out_data_s;
            full_r     <= (count_s == CW'(DEPTH));
        end
    end

    assign out_data = out_data_r;
    assign out_age  = age_r;
    assign count    = count_r;
    assign full     = full_r;
    assign live     = (state_r == LIVE);

endmodule

// File: tb/tb_alu_result_log.sv
// Directed self-checking bench for alu_result_log (DEPTH 8, WIDTH 8).
module tb_alu_result_log;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       browse_prev;
    logic       browse_next;
    logic       clear;
    logic [7:0] out_data;
    logic [2:0] out_age;
    logic [3:0] count;
    logic       full;
    logic       live;

    int total;
    int bad;

    alu_result_log #(.DEPTH(8), .WIDTH(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .browse_prev(browse_prev), .browse_next(browse_next), .clear(clear),
        .out_data(out_data), .out_age(out_age), .count(count), .full(full), .live(live)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One stimulus cycle; with edge detection the controls act one clock later.
    task automatic do_cycle(input logic v, input logic [7:0] d, input logic p,
                            input logic n, input logic c);
        in_valid = v; in_data = d; browse_prev = p; browse_next = n; clear = c;
        @(negedge clock);
        in_valid = 1'b0; in_data = 8'h00; browse_prev = 1'b0; browse_next = 1'b0; clear = 1'b0;
`ifdef ALU_RESULT_LOG_EDGE_DETECT_EN
        @(negedge clock);
`endif
    endtask

    task automatic check_view(input string tag, input logic [7:0] d, input logic [2:0] a,
                              input logic l);
        check_eq({tag, "_data"}, {24'h0, out_data}, {24'h0, d});
        check_eq({tag, "_age"},  {29'h0, out_age},  {29'h0, a});
        check_eq({tag, "_live"}, {31'h0, live},     {31'h0, l});
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        browse_prev = 1'b0; browse_next = 1'b0; clear = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_view("reset", 8'h00, 3'd0, 1'b1);
        check_eq("reset_count", {28'h0, count}, 32'd0);
        check_eq("reset_full", {31'h0, full}, 32'd0);

        do_cycle(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 8'h56, 1'b0, 1'b0, 1'b0);
        check_eq("w3_count", {28'h0, count}, 32'd3);
        check_view("w3", 8'h56, 3'd0, 1'b1);

        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_view("prev1", 8'h34, 3'd1, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_view("prev2", 8'h12, 3'd2, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_view("prev3_sat", 8'h12, 3'd2, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_view("next1", 8'h34, 3'd1, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_view("next2", 8'h56, 3'd0, 1'b1);

        // Write together with next: newest becomes 0x78, view stays at age 1.
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_view("prev_34", 8'h34, 3'd1, 1'b0);
        do_cycle(1'b1, 8'h78, 1'b0, 1'b1, 1'b0);
        check_view("wr_next", 8'h56, 3'd1, 1'b0);
        check_eq("wr_next_count", {28'h0, count}, 32'd4);

        do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check_view("both", 8'h56, 3'd1, 1'b0);

        // Reset in the middle of browsing abandons the view.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_view("mid_reset", 8'h00, 3'd0, 1'b1);
        check_eq("mid_reset_count", {28'h0, count}, 32'd0);

        do_cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        check_view("clear", 8'h00, 3'd0, 1'b1);
        check_eq("clear_count", {28'h0, count}, 32'd0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_view("empty_prev", 8'h00, 3'd0, 1'b1);

        // Wrap: 0x01..0x0A into eight slots leaves 0x03 as the oldest.
        for (int i = 1; i <= 10; i++) do_cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        check_eq("wrap_full", {31'h0, full}, 32'd1);
        check_view("wrap_newest", 8'h0A, 3'd0, 1'b1);
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_view("oldest", 8'h03, 3'd7, 1'b0);
        do_cycle(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0);
        check_view("slide", 8'h04, 3'd7, 1'b0);
        check_eq("slide_count", {28'h0, count}, 32'd8);

        // Held browse_prev: single step with edge detection, saturating otherwise.
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 8'h56, 1'b0, 1'b0, 1'b0);
        browse_prev = 1'b1;
        repeat (5) @(negedge clock);
        browse_prev = 1'b0;
        repeat (2) @(negedge clock);
`ifdef ALU_RESULT_LOG_EDGE_DETECT_EN
        check_view("hold5", 8'h34, 3'd1, 1'b0);
`else
        check_view("hold5", 8'h12, 3'd2, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
